// File: rtl/cache_trace_frontend_if.sv
// cache_trace_frontend_if: trace-command input and cache-request output bundle
//   master: trace source / cache model side (drives in_*, req_ready, cache_idle)
//   slave : front end side (drives in_ready, req_*, counters, err_pulse)
interface cache_trace_frontend_if #(
   parameter int ADR_BITS      = 32,
   parameter int BYTE_OFF_BITS = 6,
   parameter int SET_BITS      = 15,
   parameter int TAG_BITS      = ADR_BITS - SET_BITS - BYTE_OFF_BITS
);
   logic                     in_valid;
   logic                     in_ready;
   logic [3:0]               in_cmd;
   logic [ADR_BITS-1:0]      in_addr;
   logic                     req_valid;
   logic                     req_ready;
   logic [3:0]               req_cmd;
   logic [TAG_BITS-1:0]      req_tag;
   logic [SET_BITS-1:0]      req_set;
   logic [BYTE_OFF_BITS-1:0] req_off;
   logic                     req_is_snoop;
   logic                     cache_idle;
   logic [31:0]              cpu_cnt;
   logic [31:0]              snp_cnt;
   logic [15:0]              err_cnt;
   logic                     err_pulse;
   modport master (
      output in_valid, in_cmd, in_addr, req_ready, cache_idle,
      input  in_ready, req_valid, req_cmd, req_tag, req_set, req_off, req_is_snoop,
             cpu_cnt, snp_cnt, err_cnt, err_pulse
   );
   modport slave (
      input  in_valid, in_cmd, in_addr, req_ready, cache_idle,
      output in_ready, req_valid, req_cmd, req_tag, req_set, req_off, req_is_snoop,
             cpu_cnt, snp_cnt, err_cnt, err_pulse
   );
endinterface

// File: rtl/cache_trace_frontend.sv
// cache_trace_frontend: FIFO-buffered trace command front end issuing pre-decoded cache requests
//   clk, rst_n (async active-low); bus (slave): in_* handshake, req_* request register,
//   cache_idle, cpu/snp issue counters, err counter and per-drop err_pulse
module cache_trace_frontend #(
   parameter int ADR_BITS      = 32,
   parameter int BYTE_OFF_BITS = 6,
   parameter int SET_BITS      = 15,
   parameter int TAG_BITS      = ADR_BITS - SET_BITS - BYTE_OFF_BITS,
   parameter int DEPTH         = 4
) (
   input logic clk,
   input logic rst_n,
   cache_trace_frontend_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   typedef enum logic {RUN, BARRIER} state_t;
   state_t state, state_nx;
   logic [3:0]          cmd_q [DEPTH];
   logic [ADR_BITS-1:0] addr_q [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [PW:0]         count;
   logic                or_valid;
   logic [3:0]          or_cmd;
   logic [ADR_BITS-1:0] or_addr;
   logic [31:0]         cpu_q, snp_q;
   logic [15:0]         err_q;
   logic [3:0]          head_cmd;
   logic                in_rdy, push, pop, load, drop_err, nonempty, accept, or_free, bar_ok;
   logic                is_nop, is_err, is_norm, is_bar;
   assign head_cmd = cmd_q[rd_ptr];
   assign nonempty = count != '0;
   assign in_rdy   = count != FULL;
   assign push     = bus.in_valid && in_rdy;
   assign is_nop   = head_cmd == 4'd7;
   assign is_err   = head_cmd >= 4'd10;
   assign is_norm  = head_cmd <= 4'd6;
   assign is_bar   = head_cmd == 4'd8 || head_cmd == 4'd9;
   assign accept   = or_valid && bus.req_ready;
   assign or_free  = !or_valid || accept;
   // barriers need a truly empty OR, not one being drained this cycle
   assign bar_ok   = !or_valid && bus.cache_idle;
   assign load     = nonempty && ((is_norm && or_free) || (is_bar && bar_ok));
   assign drop_err = nonempty && is_err;
   assign pop      = load || drop_err || (nonempty && is_nop);
   always_comb begin
      state_nx = state;
      state_nx = (state == RUN) ? ((nonempty && is_bar && !bar_ok) ? BARRIER : RUN)
                                : (load ? RUN : BARRIER);
   end
   always_ff @(posedge clk)
      if (push) begin
         cmd_q[wr_ptr]  <= bus.in_cmd;
         addr_q[wr_ptr] <= bus.in_addr;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= RUN;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         or_valid <= 1'b0;
         or_cmd   <= '0;
         or_addr  <= '0;
         cpu_q    <= '0;
         snp_q    <= '0;
         err_q    <= '0;
      end else begin
         state  <= state_nx;
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         if (load) begin
            or_valid <= 1'b1;
            or_cmd   <= head_cmd;
            or_addr  <= addr_q[rd_ptr];
         end else if (accept)
            or_valid <= 1'b0;
         if (accept && or_cmd <= 4'd2)
            cpu_q <= cpu_q + 32'd1;
         if (accept && or_cmd >= 4'd3 && or_cmd <= 4'd6)
            snp_q <= snp_q + 32'd1;
         if (drop_err && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
      end
   assign bus.in_ready     = in_rdy;
   assign bus.req_valid    = or_valid;
   assign bus.req_cmd      = or_cmd;
   assign bus.req_tag      = or_addr[ADR_BITS-1 -: TAG_BITS];
   assign bus.req_set      = or_addr[BYTE_OFF_BITS +: SET_BITS];
   assign bus.req_off      = or_addr[BYTE_OFF_BITS-1:0];
   assign bus.req_is_snoop = or_cmd >= 4'd3 && or_cmd <= 4'd6;
   assign bus.cpu_cnt      = cpu_q;
   assign bus.snp_cnt      = snp_q;
   assign bus.err_cnt      = err_q;
   assign bus.err_pulse    = drop_err;
endmodule
